mult_arbiter: RTL
=================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters sharing one 4x4 multiplier.
REQ-002 Parameter TIMEOUT, default 16, SHALL set the maximum number of cycles spent waiting for multiplier done.
REQ-003 clk_in  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 rst_in  input  1  asynchronous, active-low reset.
REQ-005 req_i  input  NREQ  per-requester request, held high until that requester's response.
REQ-006 a_i  input  NREQ x 4  per-requester operand A, stable while req_i is high.
REQ-007 b_i  input  NREQ x 4  per-requester operand B, stable while req_i is high.
REQ-008 gnt_o  output  NREQ  one-hot grant, held for the whole transaction.
REQ-009 rsp_valid_o  output  NREQ  one-cycle response strobe to the granted requester.
REQ-010 rsp_data_o  output  8  product, valid only with rsp_valid_o.
REQ-011 rsp_err_o  output  1  timeout flag, valid only with rsp_valid_o.
REQ-012 busy_o  output  1  high in every state except IDLE.
REQ-013 mul_start_o  output  1  multiplier start pulse.
REQ-014 mul_data_o  output  4  multiplier operand bus.
REQ-015 mul_result_i  input  8  multiplier product.
REQ-016 mul_done_i  input  1  multiplier completion.

Function
REQ-017 FSM states SHALL be IDLE, SEND_A, SEND_B, WAIT and RESP, and all outputs SHALL be registered (Moore).
REQ-018 IDLE: when any req_i is high, the FSM SHALL pick a winner round-robin starting at the priority pointer, latch its operands, assert gnt_o for it and go to SEND_A; otherwise it stays in IDLE.
REQ-019 SEND_A: the FSM SHALL drive mul_start_o=1 and mul_data_o=A for exactly one cycle, then go to SEND_B.
REQ-020 SEND_B: the FSM SHALL drive mul_start_o=0 and mul_data_o=B for one cycle, clear the wait counter and go to WAIT.
REQ-021 WAIT: on mul_done_i=1 the FSM SHALL capture mul_result_i, set the error bit to 0 and go to RESP.
REQ-022 WAIT timeout: if the counter reaches TIMEOUT-1 with no done, the FSM SHALL set data to 0x00, set the error bit to 1 and go to RESP.
REQ-023 WAIT with done on the same cycle as the counter limit: done SHALL win.
REQ-024 mul_done_i seen outside WAIT SHALL be ignored.
REQ-025 RESP: the FSM SHALL pulse rsp_valid_o for the granted index for one cycle, present rsp_data_o and rsp_err_o, set the pointer to the granted index+1 (mod NREQ), clear gnt_o and return to IDLE.
REQ-026 A requester that drops req_i mid-transaction SHALL NOT abort it; the response SHALL still be issued.
REQ-027 Minimum latency: req_i sampled at cycle 0 SHALL give mul_start_o at cycle 1, B at cycle 2, and rsp_valid_o one cycle after mul_done_i (earliest cycle 4).
REQ-028 New requests arriving while busy SHALL wait; no request SHALL be lost, and no requester SHALL wait more than NREQ-1 transactions.
REQ-029 Outside SEND_A/SEND_B, mul_data_o and mul_start_o SHALL be 0; outside RESP, rsp_data_o, rsp_err_o and rsp_valid_o SHALL be 0.
REQ-030 The product is unsigned 4x4 to 8 bits and SHALL be passed through unmodified.

Reset
REQ-031 rst_in=0 SHALL immediately force state IDLE, pointer 0, wait counter 0 and all outputs 0, regardless of clk_in.
REQ-032 Reset during SEND_A, SEND_B, WAIT or RESP SHALL abandon the transaction with no rsp_valid_o; the first cycle after release SHALL be IDLE.

Structure
REQ-033 Package mult_arb_pkg SHALL hold the state enum, the NREQ and TIMEOUT defaults, and the operand and result width constants (4 and 8).
REQ-034 Round-robin selection SHALL live in sub-module mult_rr_pick: combinational, taking req and pointer and returning a one-hot grant plus a valid bit.

Verification
REQ-035 Single request: req_i=0001, A=3, B=5, done two cycles after SEND_B -> mul_start_o at cycle 1, mul_data_o 3 then 5, rsp_valid_o=0001 with rsp_data_o=0x0F and rsp_err_o=0.
REQ-036 All four requesting, pointer 0 -> grant order 0,1,2,3 with one rsp_valid_o each; then req 0 and 3 re-request -> grant order 0 then 3.
REQ-037 Maximum operands: A=15, B=15 -> rsp_data_o=0xE1.
REQ-038 Timeout: mul_done_i never asserted -> rsp_valid_o 16 cycles after entering WAIT with rsp_data_o=0x00 and rsp_err_o=1; a late done is ignored.
REQ-039 Done on the timeout cycle -> rsp_err_o=0 and the product is returned.
REQ-040 Reset asserted in WAIT -> all outputs 0 asynchronously, no response issued, and the next request is granted from index 0.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the multiplier arbiter: FSM state encoding,
// default requester count and timeout, and the operand/result widths of the
// shared 4x4 unsigned multiplier.
package mult_arb_pkg;

    localparam int NREQ_DEF    = 4;
    localparam int TIMEOUT_DEF = 16;
    localparam int OP_W        = 4;
    localparam int RES_W       = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEND_A = 3'd1,
        ST_SEND_B = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

endpackage

// File: rtl/mult_rr_pick.sv
// Combinational round-robin picker: starting at ptr_i and wrapping at NREQ,
// grants the first active request. valid_o is high when any request is set.
module mult_rr_pick
    import mult_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic             valid_o
);

    logic found;

    // Scan positions ptr, ptr+1, ... (mod NREQ); the first requester seen wins.
    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path leaves a value unassigned and no latch is inferred.
        gnt_o   = '0;
        found   = 1'b0;
        valid_o = |req_i;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req_i[i] && (i == (int'(ptr_i) + k) % NREQ)) begin
                    gnt_o[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Arbiter sharing one 4x4 multiplier among NREQ requesters. A round-robin
// winner has A then B sent over a single operand bus, the product (or a
// timeout error) is returned with a one-cycle strobe. All outputs are
// registered and reflect the current FSM state.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [NREQ-1:0]           req_i,
    input  logic [NREQ-1:0][OP_W-1:0] a_i,
    input  logic [NREQ-1:0][OP_W-1:0] b_i,
    output logic [NREQ-1:0]           gnt_o,
    output logic [NREQ-1:0]           rsp_valid_o,
    output logic [RES_W-1:0]          rsp_data_o,
    output logic                      rsp_err_o,
    output logic                      busy_o,
    output logic                      mul_start_o,
    output logic [OP_W-1:0]           mul_data_o,
    input  logic [RES_W-1:0]          mul_result_i,
    input  logic                      mul_done_i
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);
    localparam logic [PTR_W-1:0] IDX_LAST  = PTR_W'(NREQ - 1);

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OP_W-1:0]    op_b_q, op_b_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [NREQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [RES_W-1:0]   rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;
    logic               busy_q, busy_d;
    logic               mul_start_q, mul_start_d;
    logic [OP_W-1:0]    mul_data_q, mul_data_d;

    logic [NREQ-1:0]    pick_gnt;
    logic               pick_valid;
    logic [PTR_W-1:0]   pick_idx;

    mult_rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .valid_o (pick_valid)
    );

    // Convert the one-hot winner into an index for operand select and pointer update.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) begin
                pick_idx = PTR_W'(i);
            end
        end
    end

    // Next-state and next-output logic; outputs are computed for the state being entered.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        op_b_d      = op_b_q;
        gnt_d       = gnt_q;
        rsp_valid_d = '0;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;
        mul_start_d = 1'b0;
        mul_data_d  = '0;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    // A goes out on the very next cycle, so only B needs holding.
                    gnt_d       = pick_gnt;
                    idx_d       = pick_idx;
                    op_b_d      = b_i[pick_idx];
                    mul_start_d = 1'b1;
                    mul_data_d  = a_i[pick_idx];
                    state_d     = ST_SEND_A;
                end
            end
            ST_SEND_A: begin
                mul_data_d = op_b_q;
                state_d    = ST_SEND_B;
            end
            ST_SEND_B: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Done is checked first so it wins on the limit cycle.
                if (mul_done_i) begin
                    rsp_valid_d = gnt_q;
                    rsp_data_d  = mul_result_i;
                    rsp_err_d   = 1'b0;
                    state_d     = ST_RESP;
                end else if (cnt_q == CNT_LIMIT) begin
                    rsp_valid_d = gnt_q;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                ptr_d   = (idx_q == IDX_LAST) ? '0 : idx_q + PTR_W'(1);
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset clears everything without waiting for a clock.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            op_b_q      <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            mul_start_q <= 1'b0;
            mul_data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of the others, independent of statement order.
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            op_b_q      <= op_b_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
            mul_start_q <= mul_start_d;
            mul_data_q  <= mul_data_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign busy_o      = busy_q;
    assign mul_start_o = mul_start_q;
    assign mul_data_o  = mul_data_q;

endmodule
